// File: rtl/pe_result_to_blockfp_pkg.sv
// Shared constants and types for the result-to-block-floating-point converter.
package pe_result_to_blockfp_pkg;

  localparam int unsigned GROUP_SIZE            = 8;
  localparam int unsigned RESULT_EXPONENT_WIDTH = 5;
  localparam int unsigned RESULT_MANTISSA_WIDTH = 10;
  localparam int unsigned RESULT_EXPONENT_BIAS  = 15;
  localparam int unsigned EXPONENT_WIDTH        = 5;
  localparam int unsigned EXPONENT_BIAS         = 15;
  localparam int unsigned FEATURE_WIDTH         = 8;

  localparam int unsigned DATA_WIDTH  = 1 + RESULT_EXPONENT_WIDTH + RESULT_MANTISSA_WIDTH;
  localparam int unsigned CNT_WIDTH   = $clog2(GROUP_SIZE);
  localparam int          REBIAS      = int'(EXPONENT_BIAS) - int'(RESULT_EXPONENT_BIAS);
  localparam int unsigned BASE_SHIFT  = RESULT_MANTISSA_WIDTH - FEATURE_WIDTH + 2;

  // Two guard bits cover both rebias directions without overflow.
  localparam int unsigned SE_WIDTH    =
    ((RESULT_EXPONENT_WIDTH > EXPONENT_WIDTH) ? RESULT_EXPONENT_WIDTH : EXPONENT_WIDTH) + 2;
  localparam int unsigned SHIFT_WIDTH = SE_WIDTH + $clog2(RESULT_MANTISSA_WIDTH + 1) + 1;

  localparam int unsigned EXP_MAX     = (2 ** EXPONENT_WIDTH) - 1;
  localparam int unsigned FEATURE_MAX = (2 ** (FEATURE_WIDTH - 1)) - 1;

  localparam logic signed [SE_WIDTH-1:0] REBIAS_S  = SE_WIDTH'(REBIAS);
  localparam logic signed [SE_WIDTH-1:0] SE_LIMIT  = SE_WIDTH'(EXP_MAX);

  typedef struct packed {
    logic                             sign;
    logic [RESULT_EXPONENT_WIDTH-1:0] exponent;
    logic [RESULT_MANTISSA_WIDTH-1:0] mantissa;
  } result_word_t;

  typedef struct packed {
    logic [EXPONENT_WIDTH-1:0]                    exponent;
    logic [GROUP_SIZE-1:0][FEATURE_WIDTH-1:0]     mantissa;
  } blockfp_group_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ALIGN   = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/pe_result_to_blockfp_if.sv
// Input result stream and output block-FP stream of the converter.
interface pe_result_to_blockfp_if;
  import pe_result_to_blockfp_pkg::*;

  logic [DATA_WIDTH-1:0]     i_data;
  logic                      i_valid;
  logic                      o_ready;
  logic                      o_valid;
  logic                      i_ready;
  logic [FEATURE_WIDTH-1:0]  o_mantissa;
  logic [EXPONENT_WIDTH-1:0] o_exponent;
  logic                      o_last;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_valid, o_mantissa, o_exponent, o_last
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_valid, o_mantissa, o_exponent, o_last
  );

endinterface

// File: rtl/pe_result_to_blockfp_align.sv
// Combinational alignment of one result word onto the group's shared exponent.
module pe_blockfp_align
  import pe_result_to_blockfp_pkg::*;
(
  input  result_word_t                     word,
  input  logic [RESULT_EXPONENT_WIDTH-1:0] emax,
  input  logic signed [SE_WIDTH-1:0]       se,
  output logic [FEATURE_WIDTH-1:0]         mantissa
);

  localparam logic [FEATURE_WIDTH-1:0] FMAX = FEATURE_WIDTH'(FEATURE_MAX);

  logic [SHIFT_WIDTH-1:0]           deficit;
  logic [SHIFT_WIDTH-1:0]           shift;
  logic [RESULT_MANTISSA_WIDTH:0]   shifted;
  logic [FEATURE_WIDTH-2:0]         mag;
  logic signed [SE_WIDTH-1:0]       neg_se;

  always_comb begin
    neg_se   = -se;
    deficit  = '0;
    // Underflowing shared exponent is folded into the shift.
    if (se < 0) deficit = SHIFT_WIDTH'(unsigned'(neg_se));
    shift    = SHIFT_WIDTH'(BASE_SHIFT) + SHIFT_WIDTH'(emax - word.exponent) + deficit;
    shifted  = {1'b1, word.mantissa} >> shift;
    mag      = (FEATURE_WIDTH-1)'(shifted);
    mantissa = '0;
    if (word.exponent == '0) begin
      mantissa = '0;
    end else if (se > SE_LIMIT) begin
      mantissa = word.sign ? -FMAX : FMAX;
    end else begin
      mantissa = word.sign ? -{1'b0, mag} : {1'b0, mag};
    end
  end

endmodule

// File: rtl/pe_result_to_blockfp.sv
// Buffers one group of result words, derives the shared exponent, then emits
// aligned two's-complement mantissas one per cycle.
module pe_result_to_blockfp
  import pe_result_to_blockfp_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  pe_result_to_blockfp_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(GROUP_SIZE - 1);

  state_t                            state;
  logic [CNT_WIDTH-1:0]              wr_cnt;
  logic [CNT_WIDTH-1:0]              rd_cnt;
  logic [RESULT_EXPONENT_WIDTH-1:0]  emax;
  logic signed [SE_WIDTH-1:0]        se;
  logic signed [SE_WIDTH-1:0]        se_next;
  logic                              ready_q;
  logic                              valid_q;
  logic [EXPONENT_WIDTH-1:0]         exponent_q;
  logic [EXPONENT_WIDTH-1:0]         exponent_next;
  logic [RESULT_EXPONENT_WIDTH-1:0]  in_exponent;
  logic [FEATURE_WIDTH-1:0]          aligned;
  logic [DATA_WIDTH-1:0]             buffer [GROUP_SIZE];

  assign in_exponent = bus.i_data[RESULT_MANTISSA_WIDTH +: RESULT_EXPONENT_WIDTH];

  // Shared exponent with all-zero, underflow and overflow handling.
  always_comb begin
    se_next       = $signed(SE_WIDTH'(emax)) + REBIAS_S;
    exponent_next = '0;
    if (emax == '0 || se_next < 0) begin
      exponent_next = '0;
    end else if (se_next > SE_LIMIT) begin
      exponent_next = '1;
    end else begin
      exponent_next = EXPONENT_WIDTH'(se_next);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      emax       <= '0;
      se         <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      exponent_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.i_valid) begin
            if (in_exponent > emax) emax <= in_exponent;
            if (wr_cnt == LAST_IDX) begin
              wr_cnt  <= '0;
              ready_q <= 1'b0;
              state   <= ALIGN;
            end else begin
              wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            end
          end
        end
        ALIGN: begin
          se         <= se_next;
          exponent_q <= exponent_next;
          valid_q    <= 1'b1;
          state      <= EMIT;
        end
        EMIT: begin
          if (bus.i_ready) begin
            if (rd_cnt == LAST_IDX) begin
              rd_cnt  <= '0;
              emax    <= '0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state   <= COLLECT;
            end else begin
              rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Group storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (state == COLLECT && bus.i_valid) buffer[wr_cnt] <= bus.i_data;
  end

  pe_blockfp_align u_align (
    .word     (result_word_t'(buffer[rd_cnt])),
    .emax     (emax),
    .se       (se),
    .mantissa (aligned)
  );

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_exponent = exponent_q;
  assign bus.o_mantissa = valid_q ? aligned : '0;
  assign bus.o_last     = valid_q && (rd_cnt == LAST_IDX);

endmodule
